step_ctrl: RTL

- Run/step/halt controller for the CPU clock-enable, driven by three raw board push-buttons.
- Synchronises and debounces each button into a single-cycle press pulse.
- A 3-state FSM turns the press pulses into a registered cpu_en that gates the CPU datapath.
- Sits between the board button pins and the CPU core. A CPU-side halt input also stops execution.

---
 rtl/step_ctrl_pkg.sv | 7 +
 rtl/btn_debounce.sv | 44 ++++
 rtl/step_ctrl.sv | 92 +++++++++
 3 files changed

// File: rtl/step_ctrl_pkg.sv
// step_ctrl_pkg: state encodings shared by the run/step/halt controller
package step_ctrl_pkg;
    localparam int RUN_STATE_W = 2;
    localparam logic [RUN_STATE_W-1:0] HALTED   = 2'd0;
    localparam logic [RUN_STATE_W-1:0] STEPPING = 2'd1;
    localparam logic [RUN_STATE_W-1:0] RUNNING  = 2'd2;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchroniser, stability counter and rising press pulse
module btn_debounce #(
    parameter int DB_CYCLES = 4,
    parameter int DB_W      = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);
    logic            sync1_q, sync2_q, stable_q, press_q;
    logic            stable_d, press_d;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic            diff, done;

    assign diff = sync2_q != stable_q;
    assign done = diff && cnt_q == DB_W'(DB_CYCLES - 1);

    always_comb begin
        cnt_d    = done || !diff ? '0 : cnt_q + DB_W'(1);
        stable_d = done ? sync2_q : stable_q;
        press_d  = done && sync2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level = stable_q;
    assign press = press_q;
endmodule

// File: rtl/step_ctrl.sv
// step_ctrl: run/step/halt FSM producing a registered CPU clock-enable from debounced buttons
module step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = 4,
    parameter int DB_W      = 20,
    parameter int STEP_LEN  = 1,
    parameter int STEP_W    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   btn_run,
    input  logic                   btn_step,
    input  logic                   btn_halt,
    input  logic                   cpu_halt,
    output logic                   cpu_en,
    output logic [RUN_STATE_W-1:0] run_state,
    output logic                   step_done
);
    logic                   run_p, step_p, halt_p;
    logic [RUN_STATE_W-1:0] state_q, state_d;
    logic [STEP_W-1:0]      step_cnt_q, step_cnt_d;
    logic                   cpu_en_q, cpu_en_d, step_done_q, step_done_d;

    btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_run (
        .clk(clk), .rst(rst), .raw(btn_run), .level(), .press(run_p));
    btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_step (
        .clk(clk), .rst(rst), .raw(btn_step), .level(), .press(step_p));
    btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_halt (
        .clk(clk), .rst(rst), .raw(btn_halt), .level(), .press(halt_p));

    always_comb begin
        state_d     = state_q;
        step_cnt_d  = step_cnt_q;
        cpu_en_d    = cpu_en_q;
        step_done_d = 1'b0;
        case (state_q)
            HALTED: begin
                if (halt_p) begin
                    state_d = HALTED;
                end else if (run_p && !cpu_halt) begin
                    state_d  = RUNNING;
                    cpu_en_d = 1'b1;
                end else if (step_p) begin
                    state_d    = STEPPING;
                    step_cnt_d = STEP_W'(STEP_LEN - 1);
                    cpu_en_d   = 1'b1;
                end
            end
            STEPPING: begin
                if (halt_p) begin
                    state_d  = HALTED;
                    cpu_en_d = 1'b0;
                end else if (step_cnt_q == '0) begin
                    state_d     = HALTED;
                    cpu_en_d    = 1'b0;
                    step_done_d = 1'b1;
                end else begin
                    step_cnt_d = step_cnt_q - STEP_W'(1);
                end
            end
            RUNNING: begin
                if (halt_p || cpu_halt) begin
                    state_d  = HALTED;
                    cpu_en_d = 1'b0;
                end
            end
            default: begin
                state_d  = HALTED;
                cpu_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HALTED;
            step_cnt_q  <= '0;
            cpu_en_q    <= 1'b0;
            step_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_cnt_q  <= step_cnt_d;
            cpu_en_q    <= cpu_en_d;
            step_done_q <= step_done_d;
        end
    end

    assign cpu_en    = cpu_en_q;
    assign run_state = state_q;
    assign step_done = step_done_q;
endmodule
